// File: rtl/axi4_lite_clint.sv
// axi4_lite_clint: AXI4-Lite slave holding the free-running 64-bit machine timer.
// mtime lo/hi are at offsets 0x0/0x4. A lo read snapshots the high half, so a
// following hi read is consistent with it.
// Optional: define CLINT_MTIMECMP_EN to add mtimecmp at 0x8/0xC and the mtip output.
module axi4_lite_clint #(
    parameter logic [31:0] BASE = 32'h0200_0000,
    parameter int unsigned DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready
`ifdef CLINT_MTIMECMP_EN
    ,
    output logic        mtip
`endif
);

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef struct packed {
        logic       err;
        logic [1:0] sel;
    } dec_t;

    // Address decode: err covers out-of-window, misaligned and absent registers.
    function automatic dec_t decode(input logic [31:0] addr);
        dec_t        d;
        logic [31:0] off;
        off   = addr - BASE;
        d.sel = off[3:2];
        d.err = (off > 32'd15) || (addr[1:0] != 2'b00);
`ifndef CLINT_MTIMECMP_EN
        if (off[3]) d.err = 1'b1;
`endif
        return d;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    r_state_t    r_state;
    w_state_t    w_state;
    logic [63:0] mtime;
    logic [15:0] prescaler;
    logic [31:0] hi_shadow;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    dec_t        r_dec, w_dec;
    logic        tick, commit, wr_lo, wr_hi;

    assign r_dec  = decode(s_araddr);
    assign w_dec  = decode(aw_addr);
    assign tick   = (prescaler == 16'(DIV - 1));
    assign commit = (w_state == W_COMMIT) && !w_dec.err;
    assign wr_lo  = commit && (w_dec.sel == 2'd0);
    assign wr_hi  = commit && (w_dec.sel == 2'd1);

    // Timer: prescaler free-runs; a committing write to a half beats the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            mtime     <= '0;
        end else begin
            prescaler <= tick ? 16'd0 : prescaler + 16'd1;
            if (wr_lo)
                mtime <= {mtime[63:32], apply_strb(mtime[31:0], w_data, w_strb)};
            else if (wr_hi)
                mtime <= {apply_strb(mtime[63:32], w_data, w_strb), mtime[31:0]};
            else if (tick)
                mtime <= mtime + 64'd1;
        end
    end

`ifdef CLINT_MTIMECMP_EN
    logic [63:0] mtimecmp;
    logic        wr_cmp_lo, wr_cmp_hi;
    assign wr_cmp_lo = commit && (w_dec.sel == 2'd2);
    assign wr_cmp_hi = commit && (w_dec.sel == 2'd3);

    // Compare register and registered interrupt-pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= '1;
            mtip     <= 1'b0;
        end else begin
            if (wr_cmp_lo) mtimecmp[31:0]  <= apply_strb(mtimecmp[31:0], w_data, w_strb);
            if (wr_cmp_hi) mtimecmp[63:32] <= apply_strb(mtimecmp[63:32], w_data, w_strb);
            mtip <= (mtime >= mtimecmp);
        end
    end
`endif

    // Read channel: accept AR, register data/resp, hold until R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b1;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= 2'b00;
            hi_shadow <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (s_arvalid) begin
                    s_arready <= 1'b0;
                    s_rvalid  <= 1'b1;
                    r_state   <= R_RESP;
                    if (r_dec.err) begin
                        s_rdata <= '0;
                        s_rresp <= 2'b10;
                    end else begin
                        s_rresp <= 2'b00;
                        case (r_dec.sel)
                            2'd0: begin
                                s_rdata   <= mtime[31:0];
                                hi_shadow <= mtime[63:32];
                            end
                            2'd1:    s_rdata <= hi_shadow;
`ifdef CLINT_MTIMECMP_EN
                            2'd2:    s_rdata <= mtimecmp[31:0];
                            2'd3:    s_rdata <= mtimecmp[63:32];
`endif
                            default: s_rdata <= '0;
                        endcase
                    end
                end
                R_RESP: if (s_rready) begin
                    s_rvalid  <= 1'b0;
                    s_arready <= 1'b1;
                    r_state   <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write channel: capture AW and W independently, commit once, then respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
            aw_addr   <= '0;
            w_data    <= '0;
            w_strb    <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_awvalid && s_awready) begin
                        aw_addr   <= s_awaddr;
                        s_awready <= 1'b0;
                    end
                    if (s_wvalid && s_wready) begin
                        w_data   <= s_wdata;
                        w_strb   <= s_wstrb;
                        s_wready <= 1'b0;
                    end
                    // A deasserted ready means that channel is already held.
                    if ((!s_awready || s_awvalid) && (!s_wready || s_wvalid))
                        w_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= w_dec.err ? 2'b10 : 2'b00;
                    w_state  <= W_RESP;
                end
                W_RESP: if (s_bready) begin
                    s_bvalid  <= 1'b0;
                    s_awready <= 1'b1;
                    s_wready  <= 1'b1;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_clint.sv
// Bench for axi4_lite_clint: two instances (DIV=4 and DIV=1) share one bus and
// are checked against a closed-form timer model (mtime as a function of edge count).
module tb_axi4_lite_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready [2], wready [2], bvalid [2], arready [2], rvalid [2], mtip [2];
    logic [1:0]  bresp [2], rresp [2];
    logic [31:0] rdata [2];

    int cmp_cnt = 0, err_cnt = 0;
    int n = 0;   // non-reset edges since the last reset edge

    // Model state: mtime(e) = m_base + e/DIV - k_base/DIV for edges e >= k_base.
    logic [63:0] m_base [2];
    int          k_base [2];
    logic [31:0] shadow [2];
    logic [63:0] cmpm   [2];

    always #5 clk = ~clk;
    always @(posedge clk) n <= rst ? 0 : n + 1;

    axi4_lite_clint #(.BASE(BASE), .DIV(4)) u0 (
        .clk(clk), .rst(rst),
        .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready[0]),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready[0]),
        .s_bresp(bresp[0]), .s_bvalid(bvalid[0]), .s_bready(bready),
        .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready[0]),
        .s_rdata(rdata[0]), .s_rresp(rresp[0]), .s_rvalid(rvalid[0]), .s_rready(rready)
`ifdef CLINT_MTIMECMP_EN
        , .mtip(mtip[0])
`endif
    );

    axi4_lite_clint #(.BASE(BASE), .DIV(1)) u1 (
        .clk(clk), .rst(rst),
        .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready[1]),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready[1]),
        .s_bresp(bresp[1]), .s_bvalid(bvalid[1]), .s_bready(bready),
        .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready[1]),
        .s_rdata(rdata[1]), .s_rresp(rresp[1]), .s_rvalid(rvalid[1]), .s_rready(rready)
`ifdef CLINT_MTIMECMP_EN
        , .mtip(mtip[1])
`endif
    );

`ifndef CLINT_MTIMECMP_EN
    assign mtip[0] = 1'b0;
    assign mtip[1] = 1'b0;
`endif

    function automatic int dv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [63:0] mt(input int i, input int e);
        return m_base[i] + 64'(e / dv(i)) - 64'(k_base[i] / dv(i));
    endfunction

    function automatic logic is_err(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off >= 16 || addr[1:0] != 0) return 1'b1;
`ifdef CLINT_MTIMECMP_EN
        return 1'b0;
`else
        return off >= 8;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s u%0d: got %0h want %0h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_base[i] = '0; k_base[i] = 0; shadow[i] = '0; cmpm[i] = '1;
        end
    endtask

    // Register update landing on edge kc; the other half keeps its value from edge kc-1.
    task automatic model_write(input int i, input logic [31:0] addr, input logic [31:0] d,
                               input logic [3:0] s, input int kc);
        logic [63:0] pre;
        logic [31:0] off;
        if (is_err(addr)) return;
        off = addr - BASE;
        pre = mt(i, kc - 1);
        case (off)
            0: begin m_base[i] = {pre[63:32], merge(pre[31:0], d, s)}; k_base[i] = kc; end
            4: begin m_base[i] = {merge(pre[63:32], d, s), pre[31:0]}; k_base[i] = kc; end
            8:  cmpm[i][31:0]  = merge(cmpm[i][31:0], d, s);
            12: cmpm[i][63:32] = merge(cmpm[i][63:32], d, s);
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    // Single read from a negedge; hold>0 keeps rready low with arvalid asserted.
    task automatic axi_read(input logic [31:0] addr, input int hold);
        logic [31:0] ed [2];
        logic [1:0]  er;
        logic [31:0] off;
        int h;
        for (int i = 0; i < 2; i++) chk("arready_idle", i, arready[i], 1);
        araddr = addr; arvalid = 1'b1;
        h   = n + 1;
        off = addr - BASE;
        er  = is_err(addr) ? 2'b10 : 2'b00;
        for (int i = 0; i < 2; i++) begin
            ed[i] = '0;
            if (er == 2'b00) begin
                case (off)
                    0: begin ed[i] = mt(i, h - 1) >> 0; shadow[i] = mt(i, h - 1) >> 32; end
                    4:  ed[i] = shadow[i];
                    8:  ed[i] = cmpm[i][31:0];
                    12: ed[i] = cmpm[i][63:32];
                    default: ;
                endcase
            end
        end
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rvalid", i, rvalid[i], 1);
            chk("rdata", i, rdata[i], ed[i]);
            chk("rresp", i, rresp[i], er);
            chk("arready_busy", i, arready[i], 0);
        end
        if (hold > 0) begin
            araddr = BASE + 4; arvalid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    chk("rvalid_hold", i, rvalid[i], 1);
                    chk("rdata_hold", i, rdata[i], ed[i]);
                    chk("arready_hold", i, arready[i], 0);
                end
            end
        end
        rready = 1'b1; arvalid = 1'b0;
        @(negedge clk);
        rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rvalid_done", i, rvalid[i], 0);
            chk("arready_back", i, arready[i], 1);
        end
    endtask

    // Write; gap>0 sends AW gap cycles before W, gap<0 sends W first.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                             input int gap, input int hold);
        int ag, kc;
        logic [1:0] er;
        ag = (gap < 0) ? -gap : gap;
        er = is_err(addr) ? 2'b10 : 2'b00;
        if (gap >= 0) begin awaddr = addr; awvalid = 1'b1; end
        if (gap <= 0) begin wdata = d; wstrb = s; wvalid = 1'b1; end
        for (int t = 0; t < ag; t++) begin
            @(negedge clk);
            if (gap > 0) awvalid = 1'b0; else wvalid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                chk("held_ready", i, (gap > 0) ? awready[i] : wready[i], 0);
                chk("other_ready", i, (gap > 0) ? wready[i] : awready[i], 1);
            end
        end
        if (gap > 0) begin wdata = d; wstrb = s; wvalid = 1'b1; end
        if (gap < 0) begin awaddr = addr; awvalid = 1'b1; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        kc = n + 1;
        for (int i = 0; i < 2; i++) begin
            model_write(i, addr, d, s, kc);
            chk("bvalid_commit", i, bvalid[i], 0);
            chk("awready_commit", i, awready[i], 0);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("bvalid", i, bvalid[i], 1);
            chk("bresp", i, bresp[i], er);
            chk("wready_resp", i, wready[i], 0);
        end
        if (hold > 0) begin
            awaddr = BASE; awvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    chk("bvalid_hold", i, bvalid[i], 1);
                    chk("bresp_hold", i, bresp[i], er);
                    chk("awready_hold", i, awready[i], 0);
                end
            end
        end
        bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        bready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bvalid_done", i, bvalid[i], 0);
            chk("awready_back", i, awready[i], 1);
            chk("wready_back", i, wready[i], 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] addrs [8];
        addrs = '{BASE, BASE + 4, BASE + 8, BASE + 12, BASE + 32'h10, BASE + 2,
                  BASE + 32'h40, 32'h0100_0000};
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_arready", i, arready[i], 1);
            chk("rst_awready", i, awready[i], 1);
            chk("rst_wready", i, wready[i], 1);
            chk("rst_rvalid", i, rvalid[i], 0);
            chk("rst_bvalid", i, bvalid[i], 0);
            chk("rst_rdata", i, rdata[i], 0);
            chk("rst_resp", i, {bresp[i], rresp[i]}, 0);
            chk("rst_mtip", i, mtip[i], 0);
        end
        rst = 1'b0;

        // Free-run then first read (DIV=4 instance shows 10 after 40 edges).
        idle(40);
        axi_read(BASE, 0);

        // hi then lo=all ones; lo wraps and carries into hi, shadow keeps pair consistent.
        axi_write(BASE + 4, 32'h0000_0001, 4'hF, 2, 0);
        axi_write(BASE, 32'hFFFF_FFFF, 4'hF, 0, 0);
        idle(6);
        axi_read(BASE, 0);
        axi_read(BASE + 4, 0);

        // Byte strobe on lo, W arriving before AW.
        do_reset();
        axi_write(BASE, 32'h0000_AB00, 4'b0010, -1, 0);
        axi_read(BASE, 0);

        // Decode errors on read and write; writes must leave mtime alone.
        axi_read(BASE + 32'h10, 0);
        axi_read(BASE + 2, 0);
        axi_read(BASE + 8, 0);
        axi_write(BASE + 32'h20, 32'hDEAD_BEEF, 4'hF, 0, 0);
        axi_write(BASE + 1, 32'hDEAD_BEEF, 4'hF, 1, 0);
        axi_read(BASE, 0);
        axi_read(BASE + 4, 0);

        // Backpressure with new requests pending.
        axi_read(BASE, 5);
        axi_write(BASE + 4, 32'h0000_0010, 4'hF, 1, 5);
        axi_read(BASE, 0);
        axi_read(BASE + 4, 0);

        // Reset while rvalid is pending drops it on the reset edge.
        araddr = BASE; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 2; i++) chk("rvalid_pre_rst", i, rvalid[i], 1);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rvalid_rst", i, rvalid[i], 0);
            chk("arready_rst", i, arready[i], 1);
        end
        rst = 1'b0;
        model_reset();
        axi_read(BASE, 0);
        axi_read(BASE + 4, 0);

        // Randomized mix of reads, writes and idle gaps.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0: axi_read(addrs[$urandom_range(0, 7)], 0);
                1: axi_write(addrs[$urandom_range(0, 7)], $urandom, 4'($urandom_range(0, 15)),
                             int'($urandom_range(0, 4)) - 2, 0);
                default: idle($urandom_range(0, 5));
            endcase
        end
        axi_read(BASE, 0);
        axi_read(BASE + 4, 0);

`ifdef CLINT_MTIMECMP_EN
        // mtip tracks mtime >= mtimecmp one cycle late.
        do_reset();
        axi_write(BASE + 8, 32'd100, 4'hF, 0, 0);
        axi_write(BASE + 12, 32'd0, 4'hF, 0, 0);
        axi_read(BASE + 8, 0);
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk("mtip", i, mtip[i], mt(i, n - 1) >= cmpm[i]);
        end
        axi_write(BASE + 12, 32'hFFFF_FFFF, 4'hF, 0, 0);
        axi_write(BASE + 8, 32'hFFFF_FFFF, 4'hF, 0, 0);
        idle(2);
        for (int i = 0; i < 2; i++) chk("mtip_clear", i, mtip[i], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
